// File: rtl/weight_mem_arbiter_if.sv
// Bundle of the host write channel, sequencer read channel and SRAM port
// seen by weight_mem_arbiter. The arbiter uses the slave modport.
interface weight_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter int CW = 3
);
  // Host channel: a write is transferred in every cycle with host_wvalid & host_wready;
  // cmp_req/cmp_addr stay stable until cmp_gnt, and cmp_rvalid follows cmp_gnt by one cycle.
  logic          host_wvalid;
  logic          host_wready;
  logic [AW-1:0] host_waddr;
  logic [DW-1:0] host_wdata;
  logic          cmp_req;
  logic [AW-1:0] cmp_addr;
  logic          cmp_gnt;
  logic          cmp_rvalid;
  logic [DW-1:0] cmp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] buf_count;

  modport slave (
    input  host_wvalid, host_waddr, host_wdata, cmp_req, cmp_addr, mem_rdata,
    output host_wready, cmp_gnt, cmp_rvalid, cmp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, buf_count
  );

  modport master (
    output host_wvalid, host_waddr, host_wdata, cmp_req, cmp_addr, mem_rdata,
    input  host_wready, cmp_gnt, cmp_rvalid, cmp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, buf_count
  );
endinterface

// File: rtl/weight_mem_arbiter.sv
// Shares the single-port weight SRAM between buffered host writes and sequencer
// reads; reads win unless the buffer has waited MAX_WAIT cycles. Forwards buffered data.
module weight_mem_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  weight_mem_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [WW-1:0] wait_q;
  logic          rvalid_q, fwd_q;
  logic [DW-1:0] fwd_data_q;

  logic          empty, full, push, force_drain, gnt, drain;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign push        = bus.host_wvalid & bus.host_wready;
  assign force_drain = (wait_q == WW'(MAX_WAIT)) & ~empty;
  assign gnt         = bus.cmp_req & ~force_drain & ~rst;
  assign drain       = ~empty & ~gnt & ~rst;

  assign bus.host_wready = ~rst & ~full;
  assign bus.cmp_gnt     = gnt;
  assign bus.buf_count   = count_q;
  assign bus.cmp_rvalid  = rvalid_q & ~rst;
  assign bus.cmp_rdata   = rst ? '0 : (fwd_q ? fwd_data_q : bus.mem_rdata);

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.cmp_addr;
    end else if (drain) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = addr_q[rd_ptr_q];
      bus.mem_wdata = data_q[rd_ptr_q];
    end
  end

  // Walk oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == bus.cmp_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.host_waddr;
      data_q[wr_ptr_q] <= bus.host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      rvalid_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (drain) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drain || empty)            wait_q <= '0;
      else if (wait_q != WW'(MAX_WAIT)) wait_q <= wait_q + 1'b1;
      rvalid_q   <= gnt;
      fwd_q      <= gnt & fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end
endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Directed bench for weight_mem_arbiter: a stimulus process queues expected reads
// and SRAM writes, a negedge monitor pops and compares them.
module tb_weight_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int MAX_WAIT = 8;
  localparam int CW = 3;

  logic clk;
  logic rst;
  weight_mem_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  weight_mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  // SRAM model with one-cycle read latency
  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    sram[12'h001] = 16'hC001;
    sram[12'h060] = 16'h0660;
  end
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= sram[bus.mem_addr];
    end
  end

  // scoreboard
  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] exp_wq[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmp_rvalid) begin
        if (exp_q.size() == 0) chk("unexpected_rvalid", 32'(bus.cmp_rdata), 32'hFFFF_FFFF);
        else chk("read_data", 32'(bus.cmp_rdata), 32'(exp_q.pop_front()));
      end
      if (bus.mem_en && bus.mem_we) begin
        if (exp_wq.size() == 0) chk("unexpected_mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'hFFFF_FFFF);
        else chk("mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_wq.pop_front()));
      end
    end
  end

  // driver: one cycle of stimulus, called at posedge+1
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rq, input logic [AW-1:0] ra, input logic [DW-1:0] rexp,
                      output logic gnt_s, output logic wr_s);
    bus.host_wvalid = wv;
    bus.host_waddr  = wa;
    bus.host_wdata  = wd;
    bus.cmp_req     = rq;
    bus.cmp_addr    = ra;
    @(negedge clk);
    gnt_s = bus.cmp_gnt;
    wr_s  = wv & bus.host_wready;
    if (wr_s) exp_wq.push_back({wa, wd});
    if (rq && gnt_s) exp_q.push_back(rexp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic g, w;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, g, w);
  endtask

  initial begin
    logic g, w;
    rst = 1'b1;
    bus.host_wvalid = 1'b0;
    bus.host_waddr  = '0;
    bus.host_wdata  = '0;
    bus.cmp_req     = 1'b0;
    bus.cmp_addr    = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wready", 32'(bus.host_wready), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_rvalid", 32'(bus.cmp_rvalid), 32'd0);
    chk("rst_count", 32'(bus.buf_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_wready", 32'(bus.host_wready), 32'd1);

    // fill while the sequencer keeps the port busy, then drain when idle
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'h010 + 12'(i), 16'h00A0 + 16'(i), 1'b1, 12'h000, 16'h0000, g, w);
      chk("fill_push", 32'(w), 32'd1);
      chk("fill_gnt", 32'(g), 32'd1);
    end
    chk("full_count", 32'(bus.buf_count), 32'd4);
    chk("full_wready", 32'(bus.host_wready), 32'd0);
    step(1'b1, 12'h0FF, 16'hDEAD, 1'b0, '0, '0, g, w);
    chk("no_push_when_full", 32'(w), 32'd0);
    chk("count_after_pop", 32'(bus.buf_count), 32'd3);
    idle(3);
    chk("drained_count", 32'(bus.buf_count), 32'd0);
    chk("drained_wq", 32'(exp_wq.size()), 32'd0);

    // starvation: one entry, sequencer requesting continuously
    step(1'b1, 12'h020, 16'h00B0, 1'b1, 12'h001, 16'hC001, g, w);
    chk("starve_push", 32'(w), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, '0, 1'b1, 12'h001, 16'hC001, g, w);
      chk($sformatf("starve_gnt_%0d", i), 32'(g), (i == 8) ? 32'd0 : 32'd1);
    end
    chk("starve_count", 32'(bus.buf_count), 32'd0);

    // forwarding: youngest of two buffered writes to the same address
    step(1'b1, 12'h050, 16'h1234, 1'b1, 12'h001, 16'hC001, g, w);
    step(1'b1, 12'h050, 16'h5678, 1'b1, 12'h001, 16'hC001, g, w);
    step(1'b0, '0, '0, 1'b1, 12'h050, 16'h5678, g, w);
    chk("fwd_gnt", 32'(g), 32'd1);
    idle(3);
    chk("fwd_drained", 32'(bus.buf_count), 32'd0);
    step(1'b0, '0, '0, 1'b1, 12'h050, 16'h5678, g, w);
    idle(1);

    // push and read of the same address in one cycle: read sees old SRAM
    step(1'b1, 12'h060, 16'hBEEF, 1'b1, 12'h060, 16'h0660, g, w);
    chk("same_cycle_gnt", 32'(g), 32'd1);
    idle(2);
    step(1'b0, '0, '0, 1'b1, 12'h060, 16'hBEEF, g, w);
    idle(1);

    // reset mid-operation: three buffered entries and a read in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 12'h070 + 12'(i), 16'h00C0 + 16'(i), 1'b1, 12'h001, 16'hC001, g, w);
    chk("mid_count", 32'(bus.buf_count), 32'd3);
    bus.cmp_req  = 1'b1;
    bus.cmp_addr = 12'h001;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.cmp_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cmp_req = 1'b0;
    exp_wq.delete();
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(bus.cmp_rvalid), 32'd0);
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("mid_rst_wready", 32'(bus.host_wready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_post_count", 32'(bus.buf_count), 32'd0);
    idle(12);

    chk("final_read_q", 32'(exp_q.size()), 32'd0);
    chk("final_write_q", 32'(exp_wq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
